// File: rtl/pipe_ctrl_pkg.sv
// Shared types and default stage indices for the pipeline stall/flush sequencer.
package pipe_ctrl_pkg;

   typedef enum logic [2:0] {
      ST_RUN,
      ST_MEM_WAIT,
      ST_DRAIN,
      ST_HALTED,
      ST_ERROR
   } pipe_state_e;

   localparam int STG_IF  = 0;
   localparam int STG_ID  = 1;
   localparam int STG_EX  = 2;
   localparam int STG_MEM = 3;
   localparam int STG_WB  = 4;
   localparam int N_STAGES_DEF = STG_WB + 1;

   // Per-stage control bundle in the shape the stage registers consume.
   typedef struct packed {
      logic [N_STAGES_DEF-1:0] stage_en;
      logic [N_STAGES_DEF-1:0] bubble;
   } stage_ctrl_t;

endpackage

// File: rtl/pipe_ctrl_sat_cnt.sv
// Saturating up-counter with enable; holds at all-ones once reached.
module pipe_ctrl_sat_cnt #(
   parameter int W = 32
) (
   input  logic         clk_i,
   input  logic         rst_ni,
   input  logic         en_i,
   output logic [W-1:0] cnt_o
);

   logic [W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (en_i && (cnt_q != '1)) cnt_d = cnt_q + W'(1);
   end

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) cnt_q <= '0;
      else         cnt_q <= cnt_d;
   end

   assign cnt_o = cnt_q;

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline stall/flush sequencer: merges hazards, memory waits and halt into stage controls.
// Optional performance counters are built when PIPE_CTRL_PERF_EN is defined.
module pipe_ctrl
   import pipe_ctrl_pkg::*;
#(
   parameter int N_STAGES    = N_STAGES_DEF,
   parameter int ID_STAGE    = STG_ID,
   parameter int EX_STAGE    = STG_EX,
   parameter int MEM_STAGE   = STG_MEM,
   parameter int MEM_TIMEOUT = 255,
   parameter int CNT_W       = 32
) (
   input  logic                clk_i,
   input  logic                rst_ni,
   input  logic [N_STAGES-1:0] valid_i,
   input  logic                load_use_stall_i,
   input  logic                redirect_i,
   input  logic                imem_ready_i,
   input  logic                dmem_req_i,
   input  logic                dmem_ready_i,
   input  logic                halt_req_i,
   output logic [N_STAGES-1:0] stage_en_o,
   output logic [N_STAGES-1:0] bubble_o,
   output logic                redirect_o,
   output logic                halted_o,
   output logic                mem_timeout_o,
   output logic [CNT_W-1:0]    stall_cycles_o,
   output logic [CNT_W-1:0]    flush_cnt_o
);

   localparam int WCNT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT + 1) : 1;

   pipe_state_e       state_q, state_d;
   logic [WCNT_W-1:0] wait_cnt_q, wait_cnt_d;
   logic              mem_timeout_q, mem_timeout_d;

   logic mem_wait, redir_hit, lu_hit, fetch_blk, timeout_hit;

   assign mem_wait    = dmem_req_i & valid_i[MEM_STAGE] & ~dmem_ready_i;
   assign redir_hit   = redirect_i & valid_i[EX_STAGE];
   assign lu_hit      = load_use_stall_i & valid_i[ID_STAGE];
   assign fetch_blk   = (state_q == ST_DRAIN);
   assign timeout_hit = (MEM_TIMEOUT != 0) &&
                        ((32'(wait_cnt_q) + 32'd1) == 32'(MEM_TIMEOUT));

   // NOTE: every always_comb output gets a default first, so no path can infer a latch.
   always_comb begin
      stage_en_o    = '1;
      bubble_o      = '0;
      redirect_o    = 1'b0;
      halted_o      = 1'b0;
      state_d       = state_q;
      wait_cnt_d    = wait_cnt_q;
      mem_timeout_d = mem_timeout_q;

      if (state_q == ST_ERROR) begin
         stage_en_o = '0;
      end else if (state_q == ST_HALTED) begin
         stage_en_o = '0;
         halted_o   = 1'b1;
         if (!halt_req_i) state_d = ST_RUN;
      end else if (mem_wait) begin
         // Redirect and load-use stay pending upstream and are honoured after the wait.
         for (int i = 0; i <= MEM_STAGE; i++) stage_en_o[i] = 1'b0;
         bubble_o[MEM_STAGE] = 1'b1;
         wait_cnt_d          = wait_cnt_q + WCNT_W'(1);
         if (timeout_hit) begin
            mem_timeout_d = 1'b1;
            state_d       = ST_ERROR;
         end else begin
            state_d = ST_MEM_WAIT;
         end
      end else begin
         wait_cnt_d = '0;
         if (redir_hit) begin
            redirect_o = 1'b1;
            for (int i = 0; i < EX_STAGE; i++) bubble_o[i] = 1'b1;
            if (fetch_blk) stage_en_o[0] = 1'b0;
         end else if (lu_hit) begin
            for (int i = 0; i <= ID_STAGE; i++) stage_en_o[i] = 1'b0;
            bubble_o[ID_STAGE] = 1'b1;
         end else if (!imem_ready_i || fetch_blk) begin
            stage_en_o[0] = 1'b0;
            bubble_o[0]   = 1'b1;
         end

         if (state_q == ST_DRAIN) begin
            if (!halt_req_i)                      state_d = ST_RUN;
            else if (valid_i[N_STAGES-1:1] == '0) state_d = ST_HALTED;
         end else begin
            state_d = halt_req_i ? ST_DRAIN : ST_RUN;
         end
      end

      // Reset freezes the pipe and fills every stage with bubbles immediately.
      if (!rst_ni) begin
         stage_en_o = '0;
         bubble_o   = '1;
         redirect_o = 1'b0;
         halted_o   = 1'b0;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q       <= ST_RUN;
         wait_cnt_q    <= '0;
         mem_timeout_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         wait_cnt_q    <= wait_cnt_d;
         mem_timeout_q <= mem_timeout_d;
      end
   end

   assign mem_timeout_o = mem_timeout_q;

`ifdef PIPE_CTRL_PERF_EN
   logic stall_inc;
   assign stall_inc = rst_ni && (state_q != ST_HALTED) && !(&stage_en_o);

   pipe_ctrl_sat_cnt #(.W(CNT_W)) u_stall_cnt (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .en_i   (stall_inc),
      .cnt_o  (stall_cycles_o)
   );

   pipe_ctrl_sat_cnt #(.W(CNT_W)) u_flush_cnt (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .en_i   (redirect_o),
      .cnt_o  (flush_cnt_o)
   );
`else
   assign stall_cycles_o = '0;
   assign flush_cnt_o    = '0;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: directed scenarios plus randomized traffic against a behavioural model.
module tb_pipe_ctrl;

   localparam int N   = 5;
   localparam int TO  = 4;
   localparam int CW  = 32;
   localparam int MEM = 3;
   localparam int EXS = 2;
   localparam int IDS = 1;

   logic          clk_i = 1'b0;
   logic          rst_ni;
   logic [N-1:0]  valid_i;
   logic          load_use_stall_i, redirect_i, imem_ready_i;
   logic          dmem_req_i, dmem_ready_i, halt_req_i;
   logic [N-1:0]  stage_en_o, bubble_o;
   logic          redirect_o, halted_o, mem_timeout_o;
   logic [CW-1:0] stall_cycles_o, flush_cnt_o;

   always #5 clk_i = ~clk_i;

   pipe_ctrl #(
      .N_STAGES(N), .ID_STAGE(IDS), .EX_STAGE(EXS), .MEM_STAGE(MEM),
      .MEM_TIMEOUT(TO), .CNT_W(CW)
   ) dut (
      .clk_i(clk_i), .rst_ni(rst_ni), .valid_i(valid_i),
      .load_use_stall_i(load_use_stall_i), .redirect_i(redirect_i),
      .imem_ready_i(imem_ready_i), .dmem_req_i(dmem_req_i),
      .dmem_ready_i(dmem_ready_i), .halt_req_i(halt_req_i),
      .stage_en_o(stage_en_o), .bubble_o(bubble_o), .redirect_o(redirect_o),
      .halted_o(halted_o), .mem_timeout_o(mem_timeout_o),
      .stall_cycles_o(stall_cycles_o), .flush_cnt_o(flush_cnt_o)
   );

   int n_vec = 0;
   int n_err = 0;

   // Behavioural model: plain flags and counts describing where the pipe is.
   bit            m_err, m_halted, m_drain, m_tout;
   int            m_wait;
   logic [CW-1:0] m_stall, m_flush;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic bit dmem_wait_now();
      return dmem_req_i && valid_i[MEM] && !dmem_ready_i;
   endfunction

   task automatic model_out(output logic [N-1:0] en, output logic [N-1:0] bub,
                            output logic redir, output logic halted);
      en = '1; bub = '0; redir = 1'b0; halted = 1'b0;
      if (!rst_ni) begin
         en = '0; bub = '1;
      end else if (m_err) begin
         en = '0;
      end else if (m_halted) begin
         en = '0; halted = 1'b1;
      end else if (dmem_wait_now()) begin
         en  = 5'b10000;
         bub = 5'b01000;
      end else if (redirect_i && valid_i[EXS]) begin
         redir = 1'b1;
         bub   = 5'b00011;
         if (m_drain) en = 5'b11110;
      end else if (load_use_stall_i && valid_i[IDS]) begin
         en  = 5'b11100;
         bub = 5'b00010;
      end else if (!imem_ready_i || m_drain) begin
         en  = 5'b11110;
         bub = 5'b00001;
      end
   endtask

   task automatic model_reset();
      m_err = 0; m_halted = 0; m_drain = 0; m_tout = 0; m_wait = 0;
      m_stall = '0; m_flush = '0;
   endtask

   task automatic cmp_all();
      logic [N-1:0]  en, bub;
      logic          r, h;
      logic [CW-1:0] es, ef;
      model_out(en, bub, r, h);
`ifdef PIPE_CTRL_PERF_EN
      es = m_stall; ef = m_flush;
`else
      es = '0; ef = '0;
`endif
      check("stage_en", stage_en_o, en);
      check("bubble", bubble_o, bub);
      check("redirect_o", redirect_o, r);
      check("halted_o", halted_o, h);
      check("mem_timeout_o", mem_timeout_o, m_tout);
      check("stall_cycles", stall_cycles_o, es);
      check("flush_cnt", flush_cnt_o, ef);
   endtask

   task automatic model_next();
      logic [N-1:0] en, bub;
      logic         r, h;
      model_out(en, bub, r, h);
      if (rst_ni) begin
         if (!m_halted && en != '1 && m_stall != '1) m_stall = m_stall + 1;
         if (r && m_flush != '1) m_flush = m_flush + 1;
         if (m_err) begin
         end else if (m_halted) begin
            if (!halt_req_i) m_halted = 0;
         end else if (dmem_wait_now()) begin
            m_wait++;
            m_drain = 0;
            if (TO != 0 && m_wait == TO) begin m_err = 1; m_tout = 1; end
         end else begin
            m_wait = 0;
            if (m_drain) begin
               if (!halt_req_i) m_drain = 0;
               else if (valid_i[N-1:1] == '0) begin m_drain = 0; m_halted = 1; end
            end else begin
               m_drain = halt_req_i;
            end
         end
      end
   endtask

   // Inputs change at posedge+1; outputs are compared at the following negedge.
   task automatic settle(); #4; cmp_all(); endtask
   task automatic adv(); model_next(); @(posedge clk_i); #1; endtask
   task automatic cyc(); settle(); adv(); endtask

   task automatic set_idle();
      valid_i = 5'b11111; load_use_stall_i = 0; redirect_i = 0; imem_ready_i = 1;
      dmem_req_i = 0; dmem_ready_i = 1; halt_req_i = 0;
   endtask

   // Asynchronous reset pulse launched mid-cycle, held across one edge.
   task automatic pulse_reset();
      rst_ni = 1'b0;
      #2;
      check("rst_stage_en", stage_en_o, 5'b00000);
      check("rst_bubble", bubble_o, 5'b11111);
      model_reset();
      cmp_all();
      @(posedge clk_i); #1;
      cmp_all();
      rst_ni = 1'b1;
   endtask

   int stuck;

   initial begin
      set_idle();
      rst_ni = 1'b0;
      model_reset();
      #1;
      check("init_stage_en", stage_en_o, 5'b00000);
      check("init_bubble", bubble_o, 5'b11111);
      @(posedge clk_i); @(posedge clk_i); #1;
      rst_ni = 1'b1;

      // Default run.
      settle(); check("run_en", stage_en_o, 5'b11111); adv();

      // Single-cycle load-use stall.
      load_use_stall_i = 1;
      settle();
      check("lu_en", stage_en_o, 5'b11100);
      check("lu_bub", bubble_o, 5'b00010);
      adv();
      load_use_stall_i = 0;
      settle(); check("lu_after_en", stage_en_o, 5'b11111); adv();

      // Redirect beats load-use.
      redirect_i = 1; load_use_stall_i = 1;
      settle();
      check("rd_redirect", redirect_o, 1'b1);
      check("rd_en", stage_en_o, 5'b11111);
      check("rd_bub", bubble_o, 5'b00011);
      adv();
      set_idle();

      // Three dmem wait cycles, then ready.
      dmem_req_i = 1; dmem_ready_i = 0;
      for (int i = 0; i < 3; i++) begin
         settle();
         check("mw_en", stage_en_o, 5'b10000);
         check("mw_bub", bubble_o, 5'b01000);
         adv();
      end
      dmem_ready_i = 1;
      settle(); check("mw_done_en", stage_en_o, 5'b11111); adv();
      set_idle();

      // Timeout after TO wait cycles; frozen until reset.
      dmem_req_i = 1; dmem_ready_i = 0;
      for (int i = 0; i < TO; i++) begin
         settle(); check("to_pre", mem_timeout_o, 1'b0); adv();
      end
      set_idle();
      for (int i = 0; i < 3; i++) begin
         settle();
         check("to_flag", mem_timeout_o, 1'b1);
         check("to_en", stage_en_o, 5'b00000);
         check("to_bub", bubble_o, 5'b00000);
         adv();
      end
      pulse_reset();
      settle(); check("to_cleared", mem_timeout_o, 1'b0); adv();

      // Halt with three valid instructions draining out.
      halt_req_i = 1; valid_i = 5'b01110;
      cyc();
      valid_i = 5'b11100;
      settle();
      check("dr_en", stage_en_o, 5'b11110);
      check("dr_bub", bubble_o, 5'b00001);
      adv();
      valid_i = 5'b11000; cyc();
      valid_i = 5'b10000; cyc();
      valid_i = 5'b00000;
      settle(); check("dr_not_yet", halted_o, 1'b0); adv();
      settle(); check("hl_halted", halted_o, 1'b1); check("hl_en", stage_en_o, 5'b00000); adv();
      halt_req_i = 0;
      settle(); check("hl_exit_cycle", halted_o, 1'b1); adv();
      valid_i = 5'b11111;
      settle(); check("hl_run_en", stage_en_o, 5'b11111); check("hl_run_h", halted_o, 1'b0); adv();

      // Reset in the middle of a memory wait.
      dmem_req_i = 1; dmem_ready_i = 0;
      cyc(); cyc(); cyc();
      pulse_reset();
      set_idle();
      settle();
      check("post_rst_stall", stall_cycles_o, '0);
      check("post_rst_en", stage_en_o, 5'b11111);
      adv();

      // Randomized traffic.
      stuck = 0;
      for (int c = 0; c < 4000; c++) begin
         valid_i          = 5'($urandom);
         load_use_stall_i = ($urandom_range(0, 3) == 0);
         redirect_i       = ($urandom_range(0, 4) == 0);
         imem_ready_i     = ($urandom_range(0, 4) != 0);
         if (stuck == 0 && $urandom_range(0, 60) == 0) stuck = 6;
         if (stuck > 0) begin
            dmem_req_i = 1; dmem_ready_i = 0; valid_i[MEM] = 1'b1; stuck--;
         end else begin
            dmem_req_i   = ($urandom_range(0, 4) < 2);
            dmem_ready_i = ($urandom_range(0, 4) < 3);
         end
         if ($urandom_range(0, 30) == 0) halt_req_i = ~halt_req_i;
         if (halt_req_i && $urandom_range(0, 2) == 0) valid_i[N-1:1] = '0;
         if ((m_err && $urandom_range(0, 4) == 0) || $urandom_range(0, 300) == 0) begin
            pulse_reset();
            stuck = 0;
         end else begin
            cyc();
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
